// File: rtl/pipe_pkg.sv
// Shared types and constants for the pipeline hold/flush controller.
//   pipe_state_e : controller FSM state (RUN / HOLD / REDIRECT)
//   NOP_INSTR    : instruction word loaded into a bubbled IF/ID
//   BUBBLE_CTRL  : control word loaded into a bubbled ID/EX or EX/MEM
//   PC_INC       : sequential fetch increment
package pipe_pkg;

    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_HOLD     = 2'd1,
        ST_REDIRECT = 2'd2
    } pipe_state_e;

    localparam logic [31:0] NOP_INSTR   = 32'd0;
    localparam logic [7:0]  BUBBLE_CTRL = 8'd0;
    localparam int unsigned PC_INC      = 4;

endpackage : pipe_pkg

// File: rtl/pipe_reg.sv
// Width-parameterised pipeline register.
//   clk, rst : clock, synchronous active-high reset (loads BUBBLE)
//   en       : load d when 1, keep when 0
//   flush    : load BUBBLE; wins over en
//   d, q     : payload in / out
module pipe_reg #(
    parameter int unsigned  W      = 8,
    parameter logic [W-1:0] BUBBLE = '0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         en,
    input  logic         flush,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    always_ff @(posedge clk) begin
        if (rst) begin
            q <= BUBBLE;
        end else if (flush) begin
            q <= BUBBLE;
        end else if (en) begin
            q <= d;
        end
    end

endmodule : pipe_reg

// File: rtl/pipe_hold_ctrl.sv
// Pipeline hold/flush controller: owns the PC and the IF/ID, ID/EX (control)
// and EX/MEM (control) registers, applies hazard-unit stalls and bubbles,
// redirects the PC on a taken branch and flags a stuck hold (hang).
// Ports:
//   clk, rst                  clock, synchronous active-high reset
//   hold_i, id_flush_i,       hazard unit controls
//   ex_flush_i
//   br_taken_i, br_target_i   branch redirect from ID
//   if_instr_i                instruction fetched at pc_o
//   id_ctrl_i                 control word decoded from if_id_instr_o
//   pc_o                      fetch PC
//   if_id_*_o                 IF/ID pc, instruction, valid
//   id_ex_*_o, ex_mem_*_o     control word and valid of ID/EX and EX/MEM
//   state_o                   FSM state (RUN=0, HOLD=1, REDIRECT=2)
//   hang_o                    sticky: hold_i stayed high MAX_HOLD cycles
// Optional (macro PIPE_PERF_CNT_EN): stall_cnt_o / flush_cnt_o saturating
// performance counters.
module pipe_hold_ctrl
    import pipe_pkg::*;
#(
    parameter int unsigned     PC_BITS    = 32,
    parameter int unsigned     INSTR_BITS = 32,
    parameter int unsigned     CTRL_BITS  = 8,
    parameter logic [PC_BITS-1:0] RESET_PC = '0,
    parameter int unsigned     MAX_HOLD   = 15
`ifdef PIPE_PERF_CNT_EN
    ,
    parameter int unsigned     CNT_BITS   = 16
`endif
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  hold_i,
    input  logic                  id_flush_i,
    input  logic                  ex_flush_i,
    input  logic                  br_taken_i,
    input  logic [PC_BITS-1:0]    br_target_i,
    input  logic [INSTR_BITS-1:0] if_instr_i,
    input  logic [CTRL_BITS-1:0]  id_ctrl_i,
    output logic [PC_BITS-1:0]    pc_o,
    output logic [PC_BITS-1:0]    if_id_pc_o,
    output logic [INSTR_BITS-1:0] if_id_instr_o,
    output logic                  if_id_valid_o,
    output logic [CTRL_BITS-1:0]  id_ex_ctrl_o,
    output logic                  id_ex_valid_o,
    output logic [CTRL_BITS-1:0]  ex_mem_ctrl_o,
    output logic                  ex_mem_valid_o,
    output logic [1:0]            state_o,
    output logic                  hang_o
`ifdef PIPE_PERF_CNT_EN
    ,
    output logic [CNT_BITS-1:0]   stall_cnt_o,
    output logic [CNT_BITS-1:0]   flush_cnt_o
`endif
);

    localparam int unsigned IF_ID_W  = PC_BITS + INSTR_BITS + 1;
    localparam int unsigned CTRL_W   = CTRL_BITS + 1;
    localparam int unsigned HCNT_BITS = (MAX_HOLD < 1) ? 1 : $clog2(MAX_HOLD + 1);
    localparam logic [HCNT_BITS-1:0] HOLD_LIMIT = HCNT_BITS'(MAX_HOLD);

    localparam logic [IF_ID_W-1:0] IF_ID_BUBBLE =
        {PC_BITS'(0), INSTR_BITS'(NOP_INSTR), 1'b0};
    localparam logic [CTRL_W-1:0]  CTRL_BUBBLE  = {CTRL_BITS'(BUBBLE_CTRL), 1'b0};

    pipe_state_e           state_q, state_d;
    logic [PC_BITS-1:0]    pc_q, pc_d;
    logic [HCNT_BITS-1:0]  hold_cnt_q, hold_cnt_d;
    logic                  hang_q;

    // A branch only counts once its operands are ready (hold low).
    logic br_redirect;
    assign br_redirect = br_taken_i & ~hold_i;

    // Next-state, next-PC and hold-run counter.
    always_comb begin
        state_d    = ST_RUN;
        pc_d       = pc_q + PC_BITS'(PC_INC);
        hold_cnt_d = '0;
        if (hold_i) begin
            state_d = ST_HOLD;
            pc_d    = pc_q;
            hold_cnt_d = (hold_cnt_q == HOLD_LIMIT) ? hold_cnt_q
                                                    : hold_cnt_q + HCNT_BITS'(1);
        end else if (br_taken_i) begin
            state_d = ST_REDIRECT;
            pc_d    = br_target_i;
        end
    end

    // State, PC, hold counter and sticky hang flag.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_RUN;
            pc_q       <= RESET_PC;
            hold_cnt_q <= '0;
            hang_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            hold_cnt_q <= hold_cnt_d;
            hang_q     <= hang_q | (hold_cnt_d == HOLD_LIMIT);
        end
    end

    assign pc_o    = pc_q;
    assign state_o = state_q;
    assign hang_o  = hang_q;

    logic [IF_ID_W-1:0] if_id_q;
    logic [CTRL_W-1:0]  id_ex_q;
    logic [CTRL_W-1:0]  ex_mem_q;

    pipe_reg #(.W(IF_ID_W), .BUBBLE(IF_ID_BUBBLE)) u_if_id (
        .clk   (clk),
        .rst   (rst),
        .en    (~hold_i),
        .flush (br_redirect),
        .d     ({pc_q, if_instr_i, 1'b1}),
        .q     (if_id_q)
    );

    pipe_reg #(.W(CTRL_W), .BUBBLE(CTRL_BUBBLE)) u_id_ex (
        .clk   (clk),
        .rst   (rst),
        .en    (1'b1),
        .flush (hold_i | id_flush_i),
        .d     ({id_ctrl_i, if_id_valid_o}),
        .q     (id_ex_q)
    );

    pipe_reg #(.W(CTRL_W), .BUBBLE(CTRL_BUBBLE)) u_ex_mem (
        .clk   (clk),
        .rst   (rst),
        .en    (1'b1),
        .flush (ex_flush_i),
        .d     (id_ex_q),
        .q     (ex_mem_q)
    );

    assign {if_id_pc_o, if_id_instr_o, if_id_valid_o} = if_id_q;
    assign {id_ex_ctrl_o, id_ex_valid_o}              = id_ex_q;
    assign {ex_mem_ctrl_o, ex_mem_valid_o}            = ex_mem_q;

`ifdef PIPE_PERF_CNT_EN
    localparam logic [CNT_BITS-1:0] CNT_MAX = '1;

    logic flush_evt;
    assign flush_evt = id_flush_i | ex_flush_i | br_redirect;

    // Saturating stall / flush event counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            stall_cnt_o <= '0;
            flush_cnt_o <= '0;
        end else begin
            if (hold_i && stall_cnt_o != CNT_MAX) begin
                stall_cnt_o <= stall_cnt_o + CNT_BITS'(1);
            end
            if (flush_evt && flush_cnt_o != CNT_MAX) begin
                flush_cnt_o <= flush_cnt_o + CNT_BITS'(1);
            end
        end
    end
`endif

endmodule : pipe_hold_ctrl
